uart_cmd_master: RTL and testbench

- Host-side initiator for the board's single-byte UART command protocol.
- Accepts parallel write/read requests and serialises them into command frames over a byte-level UART interface:
  - write frame: 0x77 'w', addr, data;
  - read frame: 0x72 'r', addr.
- For reads, waits for the one-byte response.
- Used in the loopback bench and as a reusable on-chip master driving a remote board over the same UART link.

---
 rtl/uart_cmd_master_if.sv | 28 ++
 rtl/uart_cmd_master.sv | 157 +++++++++++++++
 tb/tb_uart_cmd_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_master_if.sv
// Request, response and byte-level UART signals of the command master.
// The master modport is the initiator's view; slave is the host/UART side.
interface uart_cmd_master_if;
   logic       i_wr_req;
   logic       i_rd_req;
   logic [7:0] i_addr;
   logic [7:0] i_wr_data;
   logic       o_busy;
   logic [7:0] o_rd_data;
   logic       o_rd_valid;
   logic       o_timeout;
   logic [7:0] o_tx_data;
   logic       o_tx_req;
   logic       i_tx_rdy;
   logic [7:0] i_rx_data;
   logic       i_rx_rdy;
   logic       o_rx_req;

   modport master (
      input  i_wr_req, i_rd_req, i_addr, i_wr_data, i_tx_rdy, i_rx_data, i_rx_rdy,
      output o_busy, o_rd_data, o_rd_valid, o_timeout, o_tx_data, o_tx_req, o_rx_req
   );

   modport slave (
      output i_wr_req, i_rd_req, i_addr, i_wr_data, i_tx_rdy, i_rx_data, i_rx_rdy,
      input  o_busy, o_rd_data, o_rd_valid, o_timeout, o_tx_data, o_tx_req, o_rx_req
   );
endinterface

// File: rtl/uart_cmd_master.sv
// UART command initiator: serialises 'w' addr data / 'r' addr frames and
// collects the one-byte read response with a timeout.
module uart_cmd_master #(
   parameter int TimeoutCycles = 1_000_000,
   parameter int GapCycles     = 16,
   parameter int CntWidth      = 20
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   uart_cmd_master_if.master  bus
);
   typedef enum logic [2:0] {
      IDLE, LOAD, STROBE, WAIT_LO, WAIT_HI, GAP, RX_WAIT, RX_ACK
   } state_t;

   localparam logic [CntWidth-1:0] GAP_LAST    = CntWidth'(GapCycles - 1);
   localparam logic [CntWidth-1:0] TIMEOUT_CNT = CntWidth'(TimeoutCycles);
   localparam logic [CntWidth-1:0] CNT_MAX     = {CntWidth{1'b1}};

   state_t                state_r, state_nx_s;
   logic [1:0]            idx_r, idx_nx_s;
   logic                  op_wr_r, op_wr_nx_s;
   logic [7:0]            addr_r, addr_nx_s;
   logic [7:0]            data_r, data_nx_s;
   logic [CntWidth-1:0]   cnt_r, cnt_nx_s, cnt_inc_s;
   logic                  last_s;
   logic                  rd_latch_s;
   logic                  timeout_s;
   logic                  drain_s;

   function automatic logic [7:0] frame_byte(input logic is_wr, input logic [1:0] idx,
                                             input logic [7:0] addr, input logic [7:0] data);
      case (idx)
         2'd0:    frame_byte = is_wr ? 8'h77 : 8'h72;
         2'd1:    frame_byte = addr;
         default: frame_byte = data;
      endcase
   endfunction

   assign last_s    = (idx_r == (op_wr_r ? 2'd2 : 2'd1));
   assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CntWidth'(1);
   // Stray bytes outside the read window are consumed; never two strobes back to back.
   assign drain_s   = bus.i_rx_rdy && !bus.o_rx_req &&
                      (state_r != RX_WAIT) && (state_r != RX_ACK);

   // Next-state and frame bookkeeping.
   always_comb begin
      state_nx_s = state_r;
      idx_nx_s   = idx_r;
      op_wr_nx_s = op_wr_r;
      addr_nx_s  = addr_r;
      data_nx_s  = data_r;
      cnt_nx_s   = cnt_r;
      rd_latch_s = 1'b0;
      timeout_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.i_wr_req || bus.i_rd_req) begin
               op_wr_nx_s = bus.i_wr_req;
               addr_nx_s  = bus.i_addr;
               data_nx_s  = bus.i_wr_data;
               idx_nx_s   = 2'd0;
               state_nx_s = LOAD;
            end else begin
               state_nx_s = IDLE;
            end
         end
         LOAD: begin
            if (bus.i_tx_rdy) state_nx_s = STROBE;
            else              state_nx_s = LOAD;
         end
         STROBE: state_nx_s = WAIT_LO;
         WAIT_LO: begin
            if (!bus.i_tx_rdy) state_nx_s = WAIT_HI;
            else               state_nx_s = WAIT_LO;
         end
         WAIT_HI: begin
            if (bus.i_tx_rdy) begin
               cnt_nx_s   = '0;
               state_nx_s = GAP;
            end else begin
               state_nx_s = WAIT_HI;
            end
         end
         GAP: begin
            if (cnt_r >= GAP_LAST) begin
               if (!last_s) begin
                  idx_nx_s   = idx_r + 2'd1;
                  state_nx_s = LOAD;
               end else if (op_wr_r) begin
                  state_nx_s = IDLE;
               end else begin
                  cnt_nx_s   = '0;
                  state_nx_s = RX_WAIT;
               end
            end else begin
               cnt_nx_s = cnt_inc_s;
            end
         end
         RX_WAIT: begin
            // A byte on the boundary cycle still beats the timeout.
            if (bus.i_rx_rdy && !bus.o_rx_req) begin
               rd_latch_s = 1'b1;
               state_nx_s = RX_ACK;
            end else if (cnt_r >= TIMEOUT_CNT) begin
               timeout_s  = 1'b1;
               state_nx_s = IDLE;
            end else begin
               cnt_nx_s = cnt_inc_s;
            end
         end
         RX_ACK:  state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State, latched request and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r        <= IDLE;
         idx_r          <= 2'd0;
         op_wr_r        <= 1'b0;
         addr_r         <= 8'h00;
         data_r         <= 8'h00;
         cnt_r          <= '0;
         bus.o_busy     <= 1'b0;
         bus.o_tx_req   <= 1'b0;
         bus.o_tx_data  <= 8'h00;
         bus.o_rx_req   <= 1'b0;
         bus.o_rd_valid <= 1'b0;
         bus.o_rd_data  <= 8'h00;
         bus.o_timeout  <= 1'b0;
      end else begin
         state_r        <= state_nx_s;
         idx_r          <= idx_nx_s;
         op_wr_r        <= op_wr_nx_s;
         addr_r         <= addr_nx_s;
         data_r         <= data_nx_s;
         cnt_r          <= cnt_nx_s;
         bus.o_busy     <= (state_nx_s != IDLE);
         bus.o_tx_req   <= (state_nx_s == STROBE);
         bus.o_rx_req   <= (state_nx_s == RX_ACK) || drain_s;
         bus.o_rd_valid <= (state_nx_s == RX_ACK);
         bus.o_timeout  <= timeout_s;
         if (state_nx_s == LOAD) begin
            bus.o_tx_data <= frame_byte(op_wr_nx_s, idx_nx_s, addr_nx_s, data_nx_s);
         end else begin
            bus.o_tx_data <= bus.o_tx_data;
         end
         if (rd_latch_s) begin
            bus.o_rd_data <= bus.i_rx_data;
         end else begin
            bus.o_rd_data <= bus.o_rd_data;
         end
      end
   end
endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: UART byte model, event monitor and
// a cycle-level reference of frame contents, spacing and read outcomes.
module tb_uart_cmd_master;
   localparam int G = 16;
   localparam int T = 300;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_cmd_master_if bus();
   uart_cmd_master #(.TimeoutCycles(T), .GapCycles(G), .CntWidth(20)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus));

   int npass = 0;
   int ntot = 0;
   int cyc = 0;
   logic [7:0] exp_rd = 8'h00;

   logic [7:0] tx_log[$];
   int         tx_cyc[$];
   int n_rx_req, n_valid, n_to, valid_cyc, to_cyc, tx_dbl, rx_dbl;
   logic prev_tx = 1'b0;
   logic prev_rx = 1'b0;

   always @(posedge clk) cyc++;

   // UART transmitter: drops ready for one cycle after each strobe.
   always @(posedge clk) begin
      logic s;
      s = bus.o_tx_req;
      #1 bus.i_tx_rdy = !s;
   end

   // UART receiver: an acknowledged byte is gone after the strobe.
   always @(posedge clk) begin
      logic s;
      s = bus.o_rx_req;
      #1 if (s) bus.i_rx_rdy = 1'b0;
   end

   always @(negedge clk) begin
      if (bus.o_tx_req) begin
         tx_log.push_back(bus.o_tx_data);
         tx_cyc.push_back(cyc);
         if (prev_tx) tx_dbl++;
      end
      if (bus.o_rx_req) begin
         n_rx_req++;
         if (prev_rx) rx_dbl++;
      end
      if (bus.o_rd_valid) begin n_valid++; valid_cyc = cyc; end
      if (bus.o_timeout) begin n_to++; to_cyc = cyc; end
      prev_tx = bus.o_tx_req;
      prev_rx = bus.o_rx_req;
   end

   task automatic clear_logs();
      tx_log.delete(); tx_cyc.delete();
      n_rx_req = 0; n_valid = 0; n_to = 0; valid_cyc = -1; to_cyc = -1;
      tx_dbl = 0; rx_dbl = 0;
   endtask

   task automatic issue(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      bus.i_wr_req = wr; bus.i_rd_req = rd; bus.i_addr = a; bus.i_wr_data = d;
      @(posedge clk); #1;
      bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!bus.o_busy) begin ok = 1'b1; break; end
      end
      ntot++; if (!ok) $display("FAIL %s_idle: busy never fell within 5000 cycles", name); else npass++;
   endtask

   task automatic wait_strobes(input int n, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         if (tx_log.size() >= n) begin ok = 1'b1; break; end
      end
      ntot++; if (!ok) $display("FAIL %s_strobes: got %0d strobes expected %0d", name, tx_log.size(), n); else npass++;
   endtask

   task automatic check_frame(input string name, input int n, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] exp_b[3];
      exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
      ntot++; if (tx_log.size() !== n) $display("FAIL %s_len: got %0d expected %0d", name, tx_log.size(), n); else npass++;
      for (int i = 0; i < n && i < tx_log.size(); i++) begin
         ntot++; if (tx_log[i] !== exp_b[i]) $display("FAIL %s_byte%0d: got %h expected %h", name, i, tx_log[i], exp_b[i]); else npass++;
         if (i > 0) begin
            ntot++;
            if (tx_cyc[i] - tx_cyc[i-1] !== G + 4)
               $display("FAIL %s_spacing%0d: got %0d expected %0d", name, i, tx_cyc[i] - tx_cyc[i-1], G + 4);
            else npass++;
         end
      end
      ntot++; if (tx_dbl !== 0) $display("FAIL %s_strobe_width: got %0d double strobes expected 0", name, tx_dbl); else npass++;
   endtask

   // Read with the response byte raised d cycles after the final strobe.
   task automatic do_read(input string name, input logic [7:0] a, input logic [7:0] resp, input int d);
      int s, r, e;
      bit accepted;
      clear_logs();
      issue(1'b0, 1'b1, a, 8'h00);
      wait_strobes(2, name);
      s = (tx_cyc.size() >= 2) ? tx_cyc[1] : cyc;
      if (d > 1) repeat (d - 1) @(posedge clk);
      #1;
      bus.i_rx_data = resp; bus.i_rx_rdy = 1'b1;
      r = cyc;
      wait_idle(name);
      repeat (6) @(negedge clk);
      bus.i_rx_rdy = 1'b0;
      e = s + 3 + G;
      accepted = (r >= e) && (r <= e + T);
      if (accepted) exp_rd = resp;
      check_frame(name, 2, 8'h72, a, 8'h00);
      ntot++; if (n_rx_req !== 1) $display("FAIL %s_rx_req: got %0d expected 1", name, n_rx_req); else npass++;
      ntot++; if (rx_dbl !== 0) $display("FAIL %s_rx_req_width: got %0d expected 0", name, rx_dbl); else npass++;
      ntot++; if (n_valid !== (accepted ? 1 : 0)) $display("FAIL %s_valid: got %0d expected %0d", name, n_valid, accepted ? 1 : 0); else npass++;
      ntot++; if (n_to !== (accepted ? 0 : 1)) $display("FAIL %s_timeout: got %0d expected %0d", name, n_to, accepted ? 0 : 1); else npass++;
      if (accepted) begin
         ntot++; if (valid_cyc !== r + 1) $display("FAIL %s_latency: got cycle %0d expected %0d", name, valid_cyc, r + 1); else npass++;
      end else begin
         ntot++; if (to_cyc !== s + G + T + 4) $display("FAIL %s_to_cycle: got %0d expected %0d", name, to_cyc, s + G + T + 4); else npass++;
      end
      ntot++; if (bus.o_rd_data !== exp_rd) $display("FAIL %s_rd_data: got %h expected %h", name, bus.o_rd_data, exp_rd); else npass++;
   endtask

   task automatic test_reset();
      ntot++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.o_busy); else npass++;
      ntot++; if (bus.o_tx_req !== 1'b0) $display("FAIL reset_tx_req: got %b expected 0", bus.o_tx_req); else npass++;
      ntot++; if (bus.o_tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", bus.o_tx_data); else npass++;
      ntot++; if (bus.o_rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", bus.o_rd_data); else npass++;
      ntot++; if ({bus.o_rx_req, bus.o_rd_valid, bus.o_timeout} !== 3'b000)
         $display("FAIL reset_pulses: got %b expected 000", {bus.o_rx_req, bus.o_rd_valid, bus.o_timeout}); else npass++;
   endtask

   task automatic test_write(input logic [7:0] a, input logic [7:0] d);
      clear_logs();
      issue(1'b1, 1'b0, a, d);
      ntot++; if (bus.o_busy !== 1'b1) $display("FAIL write_busy_rise: got %b expected 1", bus.o_busy); else npass++;
      wait_idle("write");
      repeat (4) @(negedge clk);
      check_frame("write", 3, 8'h77, a, d);
      ntot++; if (n_rx_req !== 0) $display("FAIL write_rx_req: got %0d expected 0", n_rx_req); else npass++;
      ntot++; if (n_valid + n_to !== 0) $display("FAIL write_pulses: got %0d expected 0", n_valid + n_to); else npass++;
   endtask

   task automatic test_simultaneous();
      logic [7:0] a, d;
      int n72 = 0;
      a = 8'($urandom); d = 8'($urandom);
      clear_logs();
      issue(1'b1, 1'b1, a, d);
      wait_strobes(1, "simul");
      issue(1'b0, 1'b1, 8'h55, 8'h00);
      wait_idle("simul");
      repeat (60) @(negedge clk);
      check_frame("simul", 3, 8'h77, a, d);
      foreach (tx_log[i]) if (tx_log[i] == 8'h72 && i == 0) n72++;
      ntot++; if (n72 !== 0) $display("FAIL simul_no_read: got %0d read commands expected 0", n72); else npass++;
      ntot++; if (bus.o_busy !== 1'b0) $display("FAIL simul_busy: got %b expected 0", bus.o_busy); else npass++;
   endtask

   task automatic test_stray_idle();
      clear_logs();
      @(posedge clk); #1;
      bus.i_rx_data = 8'hEE; bus.i_rx_rdy = 1'b1;
      repeat (6) @(negedge clk);
      ntot++; if (n_rx_req !== 1) $display("FAIL stray_rx_req: got %0d expected 1", n_rx_req); else npass++;
      ntot++; if (n_valid !== 0) $display("FAIL stray_valid: got %0d expected 0", n_valid); else npass++;
      ntot++; if (bus.o_rd_data !== exp_rd) $display("FAIL stray_rd_data: got %h expected %h", bus.o_rd_data, exp_rd); else npass++;
      bus.i_rx_rdy = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 1) == 1) test_write(8'($urandom), 8'($urandom));
         else do_read("rand_read", 8'($urandom), 8'($urandom), int'($urandom_range(1, 3 + G + T + 20)));
      end
   endtask

   task automatic test_reset_midframe();
      int n_before;
      clear_logs();
      issue(1'b1, 1'b0, 8'h3C, 8'hA5);
      wait_strobes(1, "rst_mid");
      repeat (3) @(posedge clk);
      #3;
      ntot++; if (bus.o_busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b expected 1", bus.o_busy); else npass++;
      rst_n = 1'b0;
      #1;
      exp_rd = 8'h00;
      ntot++; if (bus.o_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", bus.o_busy); else npass++;
      ntot++; if (bus.o_tx_data !== 8'h00) $display("FAIL rst_mid_tx_data: got %h expected 00", bus.o_tx_data); else npass++;
      ntot++; if (bus.o_rd_data !== exp_rd) $display("FAIL rst_mid_rd_data: got %h expected %h", bus.o_rd_data, exp_rd); else npass++;
      n_before = tx_log.size();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      ntot++; if (tx_log.size() !== n_before) $display("FAIL rst_mid_stale: got %0d strobes expected %0d", tx_log.size(), n_before); else npass++;
      do_read("rst_read", 8'h44, 8'h99, 40);
   endtask

   initial begin
      bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0; bus.i_addr = 8'h00; bus.i_wr_data = 8'h00;
      bus.i_tx_rdy = 1'b1; bus.i_rx_data = 8'h00; bus.i_rx_rdy = 1'b0;
      clear_logs();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      test_reset();
      test_write(8'h3C, 8'hA5);
      do_read("read", 8'h10, 8'h5A, 200);
      do_read("timeout_late", 8'h20, 8'hC3, G + T + 4);
      ntot++; if (bus.o_rd_data !== 8'h5A) $display("FAIL timeout_keep: got %h expected 5a", bus.o_rd_data); else npass++;
      do_read("boundary", 8'h21, 8'h3E, G + T + 3);
      test_simultaneous();
      test_stray_idle();
      test_random();
      test_reset_midframe();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
